// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory loader.
// Frame layout: 16-bit word count, 4 bytes per word, then one XOR checksum byte.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_HI,
      S_HDR_LO,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int CSUM_W         = 8;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words.
// Raises word_valid for one cycle after the fourth byte of each word.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic        last_byte,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  idx;
   logic [23:0] shift;

   assign last_byte = (idx == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= 2'd0;
         shift      <= 24'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            idx <= 2'd0;
         end else if (byte_en) begin
            shift <= {shift[15:0], byte_data};
            idx   <= idx + 2'd1;
            if (last_byte) begin
               word       <= {shift, byte_data};
               word_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a counted, checksummed byte frame and writes it into
// instruction memory while holding the CPU pipeline until the load succeeds.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_loaded
);

   state_t              state, state_next;
   logic [7:0]          n_hi;
   logic [15:0]         n_words;
   logic [15:0]         hdr_n;
   logic [CSUM_W-1:0]   csum;
   logic [ADDR_W-1:0]   addr;
   logic [15:0]         loaded;
   logic                fire;
   logic                data_fire;
   logic                last_byte;
   logic                word_valid;
   logic                clear;
   logic [31:0]         word;

   assign fire      = in_valid && in_ready;
   assign data_fire = fire && (state == S_DATA);
   assign hdr_n     = {n_hi, in_data};
   assign clear     = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

   byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .byte_en    (data_fire),
      .byte_data  (in_data),
      .last_byte  (last_byte),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      cpu_hold   = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_next = S_HDR_HI;
            end
         end
         S_HDR_HI: begin
            in_ready = 1'b1;
            if (fire) begin
               state_next = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            in_ready = 1'b1;
            // A count of exactly the memory depth is legal; anything above is not.
            if (fire) begin
               if (hdr_n == 16'd0) begin
                  state_next = S_CHECK;
               end else if ({1'b0, hdr_n} > (17'd1 << ADDR_W)) begin
                  state_next = S_ERR;
               end else begin
                  state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (data_fire && last_byte && ((loaded + 16'd1) == n_words)) begin
               state_next = S_CHECK;
            end
         end
         S_CHECK: begin
            in_ready = 1'b1;
            if (fire) begin
               state_next = (in_data == csum) ? S_DONE : S_ERR;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      if (state == S_DONE) begin
         cpu_hold = 1'b0;
         done     = 1'b1;
      end
      if (state == S_ERR) begin
         error = 1'b1;
      end
   end

   // The word counter steps on the same edge that raises imem_we, while the
   // address steps at the end of the write so the write sees the word index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_hi    <= 8'd0;
         n_words <= 16'd0;
         csum    <= '0;
         addr    <= '0;
         loaded  <= 16'd0;
      end else if (clear) begin
         n_hi    <= 8'd0;
         n_words <= 16'd0;
         csum    <= '0;
         addr    <= '0;
         loaded  <= 16'd0;
      end else begin
         if (fire && (state == S_HDR_HI)) begin
            n_hi <= in_data;
         end
         if (fire && (state == S_HDR_LO)) begin
            n_words <= hdr_n;
         end
         if (data_fire) begin
            csum <= csum ^ in_data;
         end
         if (data_fire && last_byte) begin
            loaded <= loaded + 16'd1;
         end
         if (word_valid) begin
            addr <= addr + ADDR_W'(1);
         end
      end
   end

   assign imem_we      = word_valid;
   assign imem_addr    = addr;
   assign imem_wdata   = word;
   assign words_loaded = loaded;

endmodule
